// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait freezes with a watchdog, and saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_write_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t           state;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             timeout_q;

    logic load_use, mem_stall, active, freeze, branch_flush;

    assign load_use  = idex_mem_read && (idex_rd != 5'd0) &&
                       ((ifid_uses_rs1 && ifid_rs1 == idex_rd) ||
                        (ifid_uses_rs2 && ifid_rs2 == idex_rd));
    assign mem_stall = mem_req && !mem_ready;
    assign active    = (state == RUN) || (state == MEM_WAIT);
    // In MEM_WAIT only mem_ready releases the freeze; mem_req is not re-sampled.
    assign freeze    = (state == RUN) ? mem_stall : (state == MEM_WAIT) ? !mem_ready : 1'b0;
    assign branch_flush = active && !freeze && branch_taken;

    always_comb begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        idex_write_en = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_hold    = 1'b0;
        case (state)
            BOOT: begin
                ifid_write_en = 1'b1;
                idex_write_en = 1'b1;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
            end
            RUN, MEM_WAIT: begin
                if (freeze) begin
                    exmem_hold = 1'b1;
                end else if (branch_taken) begin
                    // Branch beats load-use: the flush discards the dependent instruction.
                    pc_write_en   = 1'b1;
                    ifid_write_en = 1'b1;
                    idex_write_en = 1'b1;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                end else if (load_use) begin
                    idex_write_en = 1'b1;
                    idex_flush    = 1'b1;
                end else begin
                    pc_write_en   = 1'b1;
                    ifid_write_en = 1'b1;
                    idex_write_en = 1'b1;
                end
            end
            default: exmem_hold = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            wait_cnt  <= 8'd0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (active && !pc_write_en && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (branch_flush && flush_q != '1)
                flush_q <= flush_q + 1'b1;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == TMO) begin
                        state     <= ERROR;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl with a narrow counter width
// so saturation is reached quickly.
module tb_pipeline_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
    logic ifid_uses_rs1 = 0, ifid_uses_rs2 = 0, idex_mem_read = 0;
    logic branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic pc_write_en, ifid_write_en, idex_write_en, ifid_flush, idex_flush, exmem_hold;
    logic mem_timeout;
    logic [CW-1:0] stall_cycles, flush_events;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .idex_write_en(idex_write_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_hold(exmem_hold),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit [5:0] ctl;   // {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_hold}
        bit       to;
        int       sc;
        int       fe;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0;

    // Reference model: mode 0 boot, 1 run, 2 waiting on memory, 3 error.
    int mode = 0, waited = 0, m_sc = 0, m_fe = 0;
    bit m_to = 0;

    function automatic bit [5:0] rule_outputs(bit frz, bit br, bit lu);
        if (mode == 0) return 6'b011110;
        if (mode == 3) return 6'b000001;
        if (frz)       return 6'b000001;
        if (br)        return 6'b111110;
        if (lu)        return 6'b001010;
        return 6'b111000;
    endfunction

    // Called after inputs are driven for a cycle: record expectation, then advance the model.
    task automatic expect_cycle();
        exp_t e;
        bit lu, frz;
        lu = idex_mem_read && idex_rd != 0 &&
             ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd));
        frz = (mode == 1) ? (mem_req && !mem_ready) : (mode == 2) ? !mem_ready : 1'b0;
        if (!rst_n) begin
            mode = 0; waited = 0; m_sc = 0; m_fe = 0; m_to = 0;
        end
        e.cyc = cyc; e.ctl = rule_outputs(frz, branch_taken, lu);
        e.to = m_to; e.sc = m_sc; e.fe = m_fe;
        q.push_back(e);
        if (!rst_n) return;
        if (mode == 1 || mode == 2) begin
            if (!e.ctl[5]) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (!frz && branch_taken) m_fe = (m_fe < CMAX) ? m_fe + 1 : CMAX;
        end
        case (mode)
            0: mode = 1;
            1: if (frz) begin mode = 2; waited = 1; end
            2: if (!frz) begin mode = 1; waited = 0; end
               else if (waited >= T) begin mode = 3; m_to = 1; end
               else waited++;
            default: ;
        endcase
    endtask

    task automatic set_in(bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2, bit [4:0] rd,
                          bit ld, bit br, bit req, bit rdy);
        ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs1 = u1; ifid_uses_rs2 = u2;
        idex_rd = rd; idex_mem_read = ld; branch_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk); #1; cyc++;
    endtask

    task automatic cycle_in(bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2, bit [4:0] rd,
                            bit ld, bit br, bit req, bit rdy);
        step();
        set_in(rs1, rs2, u1, u2, rd, ld, br, req, rdy);
        expect_cycle();
    endtask

    task automatic idle();
        cycle_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Reset asserted between edges; released mid-cycle so the next cycle is still BOOT.
    task automatic do_reset();
        step(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0; expect_cycle();
        step(); expect_cycle();
        step(); rst_n = 1'b1; expect_cycle();
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({pc_write_en, ifid_write_en, idex_write_en, ifid_flush, idex_flush, exmem_hold} != e.ctl) begin
                    errors++;
                    $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc,
                             {pc_write_en, ifid_write_en, idex_write_en, ifid_flush, idex_flush, exmem_hold}, e.ctl);
                end
                checks++;
                if (mem_timeout != e.to) begin
                    errors++;
                    $display("FAIL mem_timeout cyc=%0d got=%b exp=%b", e.cyc, mem_timeout, e.to);
                end
                checks++;
                if (int'(stall_cycles) != e.sc) begin
                    errors++;
                    $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", e.cyc, stall_cycles, e.sc);
                end
                checks++;
                if (int'(flush_events) != e.fe) begin
                    errors++;
                    $display("FAIL flush_events cyc=%0d got=%0d exp=%0d", e.cyc, flush_events, e.fe);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        idle(); idle();
        // Load-use on rs2, then the same with rd=0 (no stall).
        cycle_in(0, 5, 0, 1, 5, 1, 0, 0, 1);
        cycle_in(0, 0, 1, 1, 0, 1, 0, 0, 1);
        idle();
        // Branch together with load-use: branch wins.
        cycle_in(7, 0, 1, 0, 7, 1, 1, 0, 1);
        idle();
        // Three memory wait cycles then ready.
        cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        // Watchdog: hold the wait past the limit, then ready must not revive it.
        for (int i = 0; i < T + 2; i++) cycle_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
        cycle_in(3, 3, 1, 1, 3, 1, 0, 0, 1);
        do_reset();
        idle();
        // Saturation of stall_cycles.
        for (int i = 0; i < 20; i++) cycle_in(9, 0, 1, 0, 9, 1, 0, 0, 1);
        for (int i = 0; i < 20; i++) cycle_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle();
        // Randomized segments, each preceded by a reset.
        for (int s = 0; s < 8; s++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                cycle_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                         1'($urandom), ($urandom_range(0, 4) == 0),
                         ($urandom_range(0, 2) == 0),
                         (s[0] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0)));
            end
        end
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
